registers_istr: RTL and testbench

REGISTERS_ISTR -- requirements
Module: registers_istr

---
 rtl/registers_istr.sv | 148 ++++++++++++++
 tb/tb_registers_istr.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/registers_istr.sv
// ----------------------------------------------------------------------------
// registers_istr
//
// Interrupt status register block for the SCSI/DMA host interface.
// It synchronizes and debounces the SCSI controller interrupt, keeps the
// DMA end-of-transfer interrupt flag, and drives the registered host
// interrupt request. It also drives the 9-bit ISTR status word, which is
// frozen while the host reads it.
//
// Ports
//   CLK         in   system clock, rising edge
//   RESET_      in   asynchronous active-low reset
//   INTA_I      in   SCSI controller interrupt (asynchronous, active-high)
//   DMA_DONE    in   one-cycle end-of-transfer pulse
//   CLR_INT     in   one-cycle CINT write strobe (clears E_INT)
//   ISTR_RD     in   level, high for the duration of a host ISTR read
//   INTENA      in   interrupt enable (masks INT_O)
//   DMAENA      in   DMA enable (qualifies DMA_DONE)
//   PRESET      in   forces debounce counter, INTS and E_INT to zero
//   FIFO_FULL   in   synchronous FIFO full flag
//   FIFO_EMPTY  in   synchronous FIFO empty flag
//   ISTR_O      out  [8:0] registered status word
//   INT_O       out  registered host interrupt request
//
// Status word: bit0 FIFO_EMPTY, bit1 FIFO_FULL, bit4 INT_P, bit5 E_INT,
//              bit6 INTS, all other bits 0.
// ----------------------------------------------------------------------------
module registers_istr (
    input  logic       CLK,
    input  logic       RESET_,
    input  logic       INTA_I,
    input  logic       DMA_DONE,
    input  logic       CLR_INT,
    input  logic       ISTR_RD,
    input  logic       INTENA,
    input  logic       DMAENA,
    input  logic       PRESET,
    input  logic       FIFO_FULL,
    input  logic       FIFO_EMPTY,
    output logic [8:0] ISTR_O,
    output logic       INT_O
);

    // Read FSM encoding
    localparam logic [0:0] ST_LIVE   = 1'b0;
    localparam logic [0:0] ST_FROZEN = 1'b1;

    logic       arm_q,    arm_d;
    logic       sync1_q,  sync1_d;
    logic       sync2_q,  sync2_d;
    logic [1:0] cnt_q,    cnt_d;
    logic       e_int_q,  e_int_d;
    logic       int_o_q,  int_o_d;
    logic [8:0] istr_q,   istr_d;
    logic [0:0] state_q,  state_d;

    logic       ints_s;
    logic       ints;
    logic       int_p;
    logic [8:0] status_word;

    always_comb begin
        // arm_q is low only on the first edge after reset release. That edge
        // must not capture INTA_I, so synchronization really starts from zero.
        arm_d   = 1'b1;
        sync1_d = arm_q & INTA_I;
        sync2_d = sync1_q;
        ints_s  = sync2_q;

        // Debounce counter: saturating count of consecutive high ints_s samples.
        if (PRESET) begin
            cnt_d = 2'd0;
        end else if (ints_s) begin
            cnt_d = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;
        end else begin
            cnt_d = 2'd0;
        end

        // INTS is defined directly by the counter being saturated, so it sets
        // and clears in the same cycles the counter does.
        ints = (cnt_q == 2'd3);

        // A set wins over a coincident clear. PRESET wins over both.
        if (PRESET) begin
            e_int_d = 1'b0;
        end else if (DMA_DONE && DMAENA) begin
            e_int_d = 1'b1;
        end else if (CLR_INT) begin
            e_int_d = 1'b0;
        end else begin
            e_int_d = e_int_q;
        end

        int_p   = ints | e_int_q;
        int_o_d = int_p & INTENA;

        status_word = {2'b00, ints, e_int_q, int_p, 2'b00, FIFO_FULL, FIFO_EMPTY};

        // Read FSM: the status word is sampled on the edge that enters FROZEN.
        // The register then holds while ISTR_RD stays high. It updates again
        // on the edge where ISTR_RD is seen low.
        state_d = state_q;
        istr_d  = status_word;
        case (state_q)
            ST_LIVE: begin
                if (ISTR_RD) begin
                    state_d = ST_FROZEN;
                end
            end
            ST_FROZEN: begin
                if (ISTR_RD) begin
                    istr_d = istr_q;
                end else begin
                    state_d = ST_LIVE;
                end
            end
            default: begin
                state_d = ST_LIVE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_) begin
        if (!RESET_) begin
            arm_q   <= 1'b0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= 2'd0;
            e_int_q <= 1'b0;
            int_o_q <= 1'b0;
            istr_q  <= 9'h000;
            state_q <= ST_LIVE;
        end else begin
            arm_q   <= arm_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            e_int_q <= e_int_d;
            int_o_q <= int_o_d;
            istr_q  <= istr_d;
            state_q <= state_d;
        end
    end

    assign ISTR_O = istr_q;
    assign INT_O  = int_o_q;

endmodule

// File: tb/tb_registers_istr.sv
// ----------------------------------------------------------------------------
// tb_registers_istr
//
// Testbench for registers_istr. Directed scenarios cover debounce, DMA
// interrupt set/clear, collision, read freeze, masking/PRESET and reset.
// A randomized phase follows. A behavioural model is advanced once per clock
// edge, and INT_O/ISTR_O are compared against it after every edge.
// ----------------------------------------------------------------------------
module tb_registers_istr;

    logic       CLK = 1'b0;
    logic       RESET_ = 1'b0;
    logic       inta_i = 1'b0;
    logic       dma_done = 1'b0;
    logic       clr_int = 1'b0;
    logic       istr_rd = 1'b0;
    logic       intena = 1'b0;
    logic       dmaena = 1'b0;
    logic       preset = 1'b0;
    logic       fifo_full = 1'b0;
    logic       fifo_empty = 1'b0;
    logic [8:0] istr_o;
    logic       int_o;

    int checks = 0;
    int errors = 0;

    registers_istr dut (
        .CLK        (CLK),
        .RESET_     (RESET_),
        .INTA_I     (inta_i),
        .DMA_DONE   (dma_done),
        .CLR_INT    (clr_int),
        .ISTR_RD    (istr_rd),
        .INTENA     (intena),
        .DMAENA     (dmaena),
        .PRESET     (preset),
        .FIFO_FULL  (fifo_full),
        .FIFO_EMPTY (fifo_empty),
        .ISTR_O     (istr_o),
        .INT_O      (int_o)
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model state ----------------
    logic       m_armed;      // first edge after reset has passed
    logic       m_s1, m_s2;   // INTA_I as seen one and two edges ago
    logic [2:0] m_ok;         // last three edges: ints_s high and PRESET low
    logic       m_e;          // E_INT
    logic       m_int_o;
    logic [8:0] m_istr;
    logic       m_rd_prev;    // ISTR_RD as sampled on the previous edge

    task automatic model_reset();
        m_armed   = 1'b0;
        m_s1      = 1'b0;
        m_s2      = 1'b0;
        m_ok      = 3'b000;
        m_e       = 1'b0;
        m_int_o   = 1'b0;
        m_istr    = 9'h000;
        m_rd_prev = 1'b0;
    endtask

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one rising edge, update the model from the inputs sampled at
    // that edge, then compare both outputs.
    task automatic step();
        logic       ints_now;
        logic       int_p;
        logic [8:0] status;
        @(posedge CLK);
        ints_now = &m_ok;
        int_p    = ints_now | m_e;
        status   = {2'b00, ints_now, m_e, int_p, 2'b00, fifo_full, fifo_empty};
        m_int_o  = int_p & intena;
        if (!(istr_rd && m_rd_prev)) m_istr = status;
        m_rd_prev = istr_rd;
        if (preset)                   m_e = 1'b0;
        else if (dma_done && dmaena)  m_e = 1'b1;
        else if (clr_int)             m_e = 1'b0;
        m_ok    = {m_ok[1:0], m_s2 & ~preset};
        m_s2    = m_s1;
        m_s1    = m_armed & inta_i;
        m_armed = 1'b1;
        #1;
        check("model_int_o", {8'b0, int_o}, {8'b0, m_int_o});
        check("model_istr", istr_o, m_istr);
    endtask

    // Assert reset between edges, check outputs clear immediately, then
    // release between edges.
    task automatic do_reset();
        @(negedge CLK);
        #2;
        RESET_ = 1'b0;
        #1;
        check("rst_istr", istr_o, 9'h000);
        check("rst_int_o", {8'b0, int_o}, 9'h000);
        model_reset();
        repeat (2) @(negedge CLK);
        #2;
        RESET_ = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();
        intena = 1'b1;
        repeat (3) step();

        // Short SCSI pulse: two synchronized samples are not enough.
        inta_i = 1'b1;
        repeat (2) step();
        inta_i = 1'b0;
        repeat (6) step();
        check("short_pulse_ints", {8'b0, istr_o[6]}, 9'h000);
        check("short_pulse_int_o", {8'b0, int_o}, 9'h000);

        // Held SCSI interrupt: INTS after 3 synchronized cycles, INT_O one later.
        inta_i = 1'b1;
        repeat (5) step();
        check("dbnc_int_o_lat", {8'b0, int_o}, 9'h000);
        step();
        check("dbnc_istr", istr_o, 9'h050);
        check("dbnc_int_o", {8'b0, int_o}, 9'h001);
        inta_i = 1'b0;
        repeat (5) step();
        check("dbnc_release", istr_o, 9'h000);

        // DMA end interrupt set and clear.
        dmaena = 1'b1;
        dma_done = 1'b1;
        step();
        dma_done = 1'b0;
        step();
        check("dma_set_istr", istr_o, 9'h030);
        check("dma_set_int_o", {8'b0, int_o}, 9'h001);
        clr_int = 1'b1;
        step();
        clr_int = 1'b0;
        step();
        check("dma_clr_int_o", {8'b0, int_o}, 9'h000);
        check("dma_clr_istr", istr_o, 9'h000);
        dmaena = 1'b0;
        dma_done = 1'b1;
        step();
        dma_done = 1'b0;
        step();
        check("dma_disabled", istr_o, 9'h000);

        // Collision: set beats clear.
        dmaena = 1'b1;
        dma_done = 1'b1;
        clr_int = 1'b1;
        step();
        dma_done = 1'b0;
        clr_int = 1'b0;
        step();
        check("collision_e_int", {8'b0, istr_o[5]}, 9'h001);
        clr_int = 1'b1;
        step();
        clr_int = 1'b0;
        repeat (2) step();

        // Read freeze.
        dma_done = 1'b1;
        fifo_empty = 1'b1;
        step();
        dma_done = 1'b0;
        step();
        check("freeze_pre", istr_o, 9'h031);
        istr_rd = 1'b1;
        step();
        clr_int = 1'b1;
        fifo_full = 1'b1;
        fifo_empty = 1'b0;
        step();
        clr_int = 1'b0;
        repeat (2) step();
        check("freeze_hold", istr_o, 9'h031);
        check("freeze_int_o_live", {8'b0, int_o}, 9'h000);
        istr_rd = 1'b0;
        step();
        check("freeze_release", istr_o, 9'h002);
        fifo_full = 1'b0;
        step();

        // Masking and PRESET.
        dma_done = 1'b1;
        step();
        dma_done = 1'b0;
        intena = 1'b0;
        repeat (3) step();
        check("mask_int_o", {8'b0, int_o}, 9'h000);
        check("mask_int_p", {8'b0, istr_o[4]}, 9'h001);
        intena = 1'b1;
        inta_i = 1'b1;
        preset = 1'b1;
        repeat (6) step();
        check("preset_flags", {6'b0, istr_o[6:4]}, 9'h000);
        check("preset_int_o", {8'b0, int_o}, 9'h000);
        preset = 1'b0;
        inta_i = 1'b0;
        repeat (6) step();

        // Reset while FROZEN with INT_O high; INTA_I high across release.
        dma_done = 1'b1;
        step();
        dma_done = 1'b0;
        step();
        istr_rd = 1'b1;
        repeat (2) step();
        check("pre_rst_int_o", {8'b0, int_o}, 9'h001);
        fifo_empty = 1'b1;
        inta_i = 1'b1;
        do_reset();
        step();
        check("post_rst_live", istr_o, 9'h001);
        istr_rd = 1'b0;
        fifo_empty = 1'b0;
        repeat (5) step();
        check("post_rst_sync_late", istr_o, 9'h000);
        step();
        check("post_rst_sync_ints", istr_o, 9'h050);
        inta_i = 1'b0;
        repeat (5) step();

        // Randomized phase.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end
            if ($urandom_range(0, 5) == 0) inta_i = ~inta_i;
            dma_done   = ($urandom_range(0, 4) == 0);
            clr_int    = ($urandom_range(0, 5) == 0);
            dmaena     = ($urandom_range(0, 3) != 0);
            intena     = ($urandom_range(0, 5) != 0);
            preset     = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 3) == 0) istr_rd = ~istr_rd;
            fifo_full  = 1'($urandom_range(0, 1));
            fifo_empty = 1'($urandom_range(0, 1));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
